// File: rtl/dff_check_pkg.sv
// dff_check_pkg: shared state encoding, limits and count saturation for the DFF response checker
package dff_check_pkg;
   typedef enum logic [1:0] {IDLE, FILL, CHECK} state_e;
   localparam int LATENCY_MAX = 8;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] m;
      m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
      return (v >= m) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/dff_delay_line.sv
// dff_delay_line: DEPTH-stage shift register of observed D with a single oldest-stage tap
module dff_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic shift_i,
   input  logic d_i,
   output logic tap_o
);
   logic [DEPTH-1:0] hist_q, hist_d;
   logic [DEPTH:0] shifted;
   always_comb begin
      shifted = {hist_q, d_i};
      hist_d = clear_i ? '0 : shift_i ? shifted[DEPTH-1:0] : hist_q;
   end
   always_ff @(posedge clock) hist_q <= reset ? '0 : hist_d;
   assign tap_o = hist_q[DEPTH-1];
endmodule

// File: rtl/dff_response_checker.sv
// dff_response_checker: checks Q == D delayed by LATENCY and Qbar == ~Q, with saturating counters
module dff_response_checker
   import dff_check_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             D_obs,
   input  logic             Q_obs,
   input  logic             Qbar_obs,
   output logic             checking,
   output logic             mismatch,
   output logic             error,
   output logic [CNT_W-1:0] checked_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [CNT_W-1:0] first_fail_index
);
   localparam int FW = $clog2(LATENCY_MAX + 1);
   state_e state_q, state_d;
   logic [FW-1:0] fill_q, fill_d;
   logic mismatch_q, mismatch_d, error_q, error_d;
   logic [CNT_W-1:0] chk_q, chk_d, mis_q, mis_d, ffi_q, ffi_d;
   logic tap, hist_clr, hist_shift, cmp, fail, hit;
   // history is wiped whenever checking is off and on the IDLE->FILL edge
   assign hist_clr = !enable || state_q == IDLE;
   assign hist_shift = enable && state_q != IDLE;
   dff_delay_line #(.DEPTH(LATENCY)) u_hist (
      .clock   (clock),
      .reset   (reset),
      .clear_i (hist_clr),
      .shift_i (hist_shift),
      .d_i     (D_obs),
      .tap_o   (tap)
   );
   always_comb begin
      state_d = !enable ? IDLE : state_q == IDLE ? FILL : (state_q == FILL && fill_q == FW'(LATENCY - 1)) ? CHECK : state_q;
      fill_d = state_q == FILL ? fill_q + 1'b1 : '0;
      cmp = enable && state_q == CHECK && !clear;
      // 4-state compare so X/Z on any observed input counts as a failure
      fail = (Q_obs !== tap) || (Qbar_obs !== ~Q_obs);
      hit = cmp && fail;
      mismatch_d = hit;
      error_d = clear ? 1'b0 : error_q || hit;
      chk_d = clear ? '0 : cmp ? CNT_W'(sat_inc(32'(chk_q), CNT_W)) : chk_q;
      mis_d = clear ? '0 : hit ? CNT_W'(sat_inc(32'(mis_q), CNT_W)) : mis_q;
      ffi_d = clear ? '0 : (hit && !error_q) ? chk_q : ffi_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         fill_q <= '0;
         mismatch_q <= 1'b0;
         error_q <= 1'b0;
         chk_q <= '0;
         mis_q <= '0;
         ffi_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q <= fill_d;
         mismatch_q <= mismatch_d;
         error_q <= error_d;
         chk_q <= chk_d;
         mis_q <= mis_d;
         ffi_q <= ffi_d;
      end
   end
   assign checking = state_q == CHECK;
   assign mismatch = mismatch_q;
   assign error = error_q;
   assign checked_count = chk_q;
   assign mismatch_count = mis_q;
   assign first_fail_index = ffi_q;
endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker: two checker instances (LATENCY=1/CNT_W=16, LATENCY=3/CNT_W=4) against an edge-counting model
module tb_dff_response_checker;
   logic clock = 1'b0;
   logic reset, enable, clear, D_obs, q1, qb1, q3, qb3;
   logic c1, mm1, er1, c3, mm3, er3;
   logic [15:0] cc1, mc1, ff1;
   logic [3:0] cc3, mc3, ff3;
   int n_checks = 0, n_pass = 0;
   int ecount = 0;
   bit dlog[4096];
   int lat[2] = '{1, 3};
   int wid[2] = '{16, 4};
   int run[2], ec[2], em[2], ef[2], ee[2], ep[2];
   bit pat[6] = '{0, 1, 0, 1, 1, 0};

   always #10 clock = ~clock;

   dff_response_checker #(.LATENCY(1), .CNT_W(16)) u_l1 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear), .D_obs(D_obs),
      .Q_obs(q1), .Qbar_obs(qb1), .checking(c1), .mismatch(mm1), .error(er1),
      .checked_count(cc1), .mismatch_count(mc1), .first_fail_index(ff1));
   dff_response_checker #(.LATENCY(3), .CNT_W(4)) u_l3 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear), .D_obs(D_obs),
      .Q_obs(q3), .Qbar_obs(qb3), .checking(c3), .mismatch(mm3), .error(er3),
      .checked_count(cc3), .mismatch_count(mc3), .first_fail_index(ff3));

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // run[m] counts consecutive enabled edges: 0 idle, 1..L filling, >L checking
   task automatic model(input int m, input bit r, input bit e, input bit c, input bit f);
      int mx;
      bit cmp;
      mx = (1 << wid[m]) - 1;
      cmp = e && !c && run[m] > lat[m];
      if (r) begin
         run[m] = 0; ec[m] = 0; em[m] = 0; ef[m] = 0; ee[m] = 0; ep[m] = 0;
      end else begin
         if (c) begin
            ec[m] = 0; em[m] = 0; ef[m] = 0; ee[m] = 0; ep[m] = 0;
         end else begin
            ep[m] = int'(cmp && f);
            if (cmp && f && ee[m] == 0) begin ef[m] = ec[m]; ee[m] = 1; end
            if (cmp && f && em[m] < mx) em[m]++;
            if (cmp && ec[m] < mx) ec[m]++;
         end
         run[m] = e ? run[m] + 1 : 0;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit c, input bit d,
                       input bit f1q, input bit f1b, input bit f3q, input bit f3b);
      bit t1, t3, v1, v3, b1, b3;
      t1 = ecount >= 1 ? dlog[ecount-1] : 1'b0;
      t3 = ecount >= 3 ? dlog[ecount-3] : 1'b0;
      v1 = t1 ^ f1q;
      v3 = t3 ^ f3q;
      b1 = f1b ? v1 : ~v1;
      b3 = f3b ? v3 : ~v3;
      reset = r; enable = e; clear = c; D_obs = d;
      q1 = v1; qb1 = b1; q3 = v3; qb3 = b3;
      dlog[ecount] = d;
      model(0, r, e, c, (v1 != t1) || (b1 == v1));
      model(1, r, e, c, (v3 != t3) || (b3 == v3));
      ecount++;
      @(posedge clock);
      #1;
      check("l1_checking", int'(c1), int'(run[0] > 1));
      check("l1_mismatch", int'(mm1), ep[0]);
      check("l1_error", int'(er1), ee[0]);
      check("l1_checked", int'(cc1), ec[0]);
      check("l1_mis_cnt", int'(mc1), em[0]);
      check("l1_first_fail", int'(ff1), ef[0]);
      check("l3_checking", int'(c3), int'(run[1] > 3));
      check("l3_mismatch", int'(mm3), ep[1]);
      check("l3_error", int'(er3), ee[1]);
      check("l3_checked", int'(cc3), ec[1]);
      check("l3_mis_cnt", int'(mc3), em[1]);
      check("l3_first_fail", int'(ff3), ef[1]);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0; D_obs = 1'b0;
      q1 = 1'b0; qb1 = 1'b1; q3 = 1'b0; qb3 = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("rst_checked", int'(cc1), 0);
      // correct stream: entry + 1 fill + 6 checks on the LATENCY=1 instance
      for (int i = 0; i < 8; i++) step(0, 1, 0, pat[i % 6], 0, 0, 0, 0);
      check("good_checked", int'(cc1), 6);
      check("good_mis_cnt", int'(mc1), 0);
      check("good_error", int'(er1), 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      // Q fault on the third CHECK sample only
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 1'($urandom), i == 4, 0, 0, 0);
         if (i == 4) check("fault_pulse", int'(mm1), 1);
         if (i == 5) check("fault_pulse_end", int'(mm1), 0);
      end
      check("fault_mis_cnt", int'(mc1), 1);
      check("fault_first", int'(ff1), 2);
      check("fault_error", int'(er1), 1);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      // Qbar stuck equal to Q for 4 CHECK cycles; also watch the LATENCY=3 fill
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 1'($urandom), 0, i >= 2 && i <= 5, 0, 0);
         if (i == 2) check("l3_fill_low", int'(c3), 0);
         if (i == 3) check("l3_fill_rise", int'(c3), 1);
      end
      check("qbar_mis_cnt", int'(mc1), 4);
      check("qbar_first", int'(ff1), 0);
      check("l3_good_mis", int'(mc3), 0);
      // clear mid-CHECK, then saturate the 4-bit counters
      step(0, 1, 1, 0, 0, 0, 0, 0);
      check("clear_checking", int'(c1), 1);
      check("clear_checked", int'(cc1), 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 1'($urandom), 0, 0, 1, 0);
      check("sat_mis_cnt", int'(mc3), 15);
      check("sat_checked", int'(cc3), 15);
      check("sat_pulse", int'(mm3), 1);
      // reset mid-CHECK with enable still high
      step(1, 1, 0, 1, 0, 0, 1, 0);
      check("rst_mid_checking", int'(c1), 0);
      check("rst_mid_mis_cnt", int'(mc3), 0);
      for (int i = 0; i < 300; i++)
         step($urandom_range(99) == 0, $urandom_range(19) != 0, $urandom_range(29) == 0, 1'($urandom),
              $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
